// File: rtl/seg7_pkg.sv
// Shared types and segment encodings for the multiplexed 7-segment scanner.
// Encodings are active-low, bit order gfedcba (bit0 = a).
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0   = 7'b1000000;
  localparam seg_t SEG_1   = 7'b1111001;
  localparam seg_t SEG_2   = 7'b0100100;
  localparam seg_t SEG_3   = 7'b0110000;
  localparam seg_t SEG_4   = 7'b0011001;
  localparam seg_t SEG_5   = 7'b0010010;
  localparam seg_t SEG_6   = 7'b0000010;
  localparam seg_t SEG_7   = 7'b1111000;
  localparam seg_t SEG_8   = 7'b0000000;
  localparam seg_t SEG_9   = 7'b0010000;
  localparam seg_t SEG_A   = 7'b0001000;
  localparam seg_t SEG_B   = 7'b0000011;
  localparam seg_t SEG_C   = 7'b1000110;
  localparam seg_t SEG_D   = 7'b0100001;
  localparam seg_t SEG_E   = 7'b0000110;
  localparam seg_t SEG_F   = 7'b0001110;
  localparam seg_t SEG_OFF = 7'h7F;

  typedef enum logic {
    BLANK,
    SHOW
  } scan_state_t;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low gfedcba segment pattern.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  always_comb begin
    case (nibble_i)
      4'h0:    seg_o = SEG_0;
      4'h1:    seg_o = SEG_1;
      4'h2:    seg_o = SEG_2;
      4'h3:    seg_o = SEG_3;
      4'h4:    seg_o = SEG_4;
      4'h5:    seg_o = SEG_5;
      4'h6:    seg_o = SEG_6;
      4'h7:    seg_o = SEG_7;
      4'h8:    seg_o = SEG_8;
      4'h9:    seg_o = SEG_9;
      4'hA:    seg_o = SEG_A;
      4'hB:    seg_o = SEG_B;
      4'hC:    seg_o = SEG_C;
      4'hD:    seg_o = SEG_D;
      4'hE:    seg_o = SEG_E;
      default: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scanner.sv
// Time-multiplexed common-anode display driver with a blanking gap before each
// digit and a frame-aligned double buffer so a new value never shows torn.
module seg7_scanner
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] value,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                blank_lz,
  input  logic                load,
  output logic [6:0]          seg_n,
  output logic                dp_n,
  output logic [DIGITS-1:0]   an_n,
  output logic                frame_done
);

  localparam int MAX_CYC = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(DIGITS - 1);

  scan_state_t         state_q, state_d;
  logic [DIG_W-1:0]    digit_q, digit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                start_q;

  logic [4*DIGITS-1:0] disp_val_q, pend_val_q;
  logic [DIGITS-1:0]   disp_dp_q, pend_dp_q;
  logic                disp_blz_q, pend_blz_q, pend_valid_q;

  logic [DIGITS-1:0]   an_d;
  seg_t                seg_d, dec_seg;
  logic                dp_d, fd_d;
  logic                frame_boundary;
  logic [DIGITS-1:0]   suppress;
  logic                upper_zero;
  logic [3:0]          cur_nib;

  // start_q turns the first edge after reset into a frame start, so the first
  // frame also announces itself on frame_done.
  // NOTE: all always_comb outputs get a default first so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    cnt_d   = cnt_q + 1'b1;
    if (start_q) begin
      state_d = BLANK;
      digit_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end
        end
        default: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign frame_boundary = !start_q && (state_q == SHOW) &&
                          (cnt_q == DWELL_LAST) && (digit_q == DIG_LAST);

  // NOTE: blocking assignments here accumulate "all higher nibbles zero" from
  // the top digit down within one evaluation; that is intended combinational use.
  always_comb begin
    upper_zero = 1'b1;
    suppress   = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      upper_zero  = upper_zero && (disp_val_q[4*d +: 4] == 4'h0);
      suppress[d] = disp_blz_q && upper_zero && (d != 0);
    end
  end

  assign cur_nib = disp_val_q[4*digit_d +: 4];

  seg7_decoder u_decoder (
    .nibble_i (cur_nib),
    .seg_o    (dec_seg)
  );

  // Outputs are computed from the next state so they change on the entry edge.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    fd_d  = (state_d == BLANK) && (digit_d == '0) && (cnt_d == '0);
    if ((state_d == SHOW) && !suppress[digit_d]) begin
      an_d[digit_d] = 1'b0;
      seg_d         = dec_seg;
      dp_d          = ~disp_dp_q[digit_d];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= BLANK;
      digit_q    <= '0;
      cnt_q      <= '0;
      start_q    <= 1'b1;
      an_n       <= '1;
      seg_n      <= SEG_OFF;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      cnt_q      <= cnt_d;
      start_q    <= 1'b0;
      an_n       <= an_d;
      seg_n      <= seg_d;
      dp_n       <= dp_d;
      frame_done <= fd_d;
    end
  end

  // A load on the boundary edge lands in pending while the old pending moves up.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      disp_blz_q   <= 1'b0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blz_q   <= 1'b0;
      pend_valid_q <= 1'b0;
    end else begin
      if (frame_boundary && pend_valid_q) begin
        disp_val_q <= pend_val_q;
        disp_dp_q  <= pend_dp_q;
        disp_blz_q <= pend_blz_q;
      end
      if (load) begin
        pend_val_q   <= value;
        pend_dp_q    <= dp_in;
        pend_blz_q   <= blank_lz;
        pend_valid_q <= 1'b1;
      end else if (frame_boundary) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scanner.sv
// Directed bench for seg7_scanner: DIGITS=4, DWELL=4, BLANK=2 (frame of 24 cycles),
// checking {frame_done, an_n, seg_n, dp_n} on every cycle of selected frames.
module tb_seg7_scanner;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110;
  localparam logic [6:0] SD = 7'b0100001;

  localparam logic [12:0] ALL_OFF = {1'b0, 4'hF, 7'h7F, 1'b1};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int lat;

  seg7_scanner #(
    .DIGITS       (4),
    .DWELL_CYCLES (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .value      (value),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .load       (load),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    while (frame_done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
  endtask

  // Starts on the negedge of a frame_done cycle, ends on the next one.
  task automatic check_frame(input string tag, input logic [27:0] segs,
                             input logic [3:0] lit, input logic [3:0] dpm,
                             input int ld0, input logic [15:0] v0,
                             input int ld1, input logic [15:0] v1,
                             input logic [3:0] ld_dp, input logic ld_blz);
    logic [12:0] exp;
    int dig, pos;
    for (int o = 0; o < 24; o++) begin
      dig = o / 6;
      pos = o % 6;
      exp = {(o == 0), 4'hF, 7'h7F, 1'b1};
      if (pos >= 2 && lit[dig])
        exp = {1'b0, ~(4'b0001 << dig), segs[7*dig +: 7], ~dpm[dig]};
      check($sformatf("%s_o%0d", tag, o), {19'b0, frame_done, an_n, seg_n, dp_n}, {19'b0, exp});
      if (o == ld0 || o == ld1) begin
        value    = (o == ld0) ? v0 : v1;
        dp_in    = ld_dp;
        blank_lz = ld_blz;
        load     = 1'b1;
      end
      tick();
      load = 1'b0;
    end
  endtask

  initial begin
    tick();
    tick();
    check("reset_hold", {19'b0, frame_done, an_n, seg_n, dp_n}, {19'b0, ALL_OFF});
    reset = 1'b0;
    wait_frame(lat);
    check("fd_latency", lat, 1);

    check_frame("f_zero",  {S0, S0, S0, S0}, 4'b1111, 4'b0000, 10, 16'h1234, -1, 16'h0, 4'b0000, 1'b0);
    check_frame("f_1234",  {S1, S2, S3, S4}, 4'b1111, 4'b0000,  9, 16'hABCD, -1, 16'h0, 4'b0000, 1'b0);
    check_frame("f_abcd",  {SA, SB, SC, SD}, 4'b1111, 4'b0000,  5, 16'h0050, -1, 16'h0, 4'b0000, 1'b1);
    check_frame("f_lz50",  {S0, S0, S5, S0}, 4'b0011, 4'b0000,  3, 16'h0000, -1, 16'h0, 4'b0000, 1'b1);
    check_frame("f_lz00",  {S0, S0, S0, S0}, 4'b0001, 4'b0000, 12, 16'h1111, 23, 16'h2222, 4'b0000, 1'b0);
    check_frame("f_1111",  {S1, S1, S1, S1}, 4'b1111, 4'b0000, -1, 16'h0, -1, 16'h0, 4'b0000, 1'b0);
    check_frame("f_2222",  {S2, S2, S2, S2}, 4'b1111, 4'b0000,  4, 16'h3333, 20, 16'h4444, 4'b0000, 1'b0);
    check_frame("f_4444",  {S4, S4, S4, S4}, 4'b1111, 4'b0000,  7, 16'h0000, -1, 16'h0, 4'b0101, 1'b0);
    check_frame("f_dp",    {S0, S0, S0, S0}, 4'b1111, 4'b0101, -1, 16'h0, -1, 16'h0, 4'b0000, 1'b0);

    tick();
    tick();
    tick();
    check("pre_reset_show", {28'b0, an_n}, {28'b0, 4'b1110});
    reset = 1'b1;
    #1;
    check("async_reset", {19'b0, frame_done, an_n, seg_n, dp_n}, {19'b0, ALL_OFF});
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("reset_mid_%0d", i), {19'b0, frame_done, an_n, seg_n, dp_n}, {19'b0, ALL_OFF});
    end
    reset = 1'b0;
    wait_frame(lat);
    check("fd_latency2", lat, 1);
    check_frame("f_after_rst", {S0, S0, S0, S0}, 4'b1111, 4'b0000, -1, 16'h0, -1, 16'h0, 4'b0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
